// File: rtl/key_repeat.sv
// Debounced key levels -> single-cycle action pulses with press, hold-delay and auto-repeat timing.
// Optional release pulses on key_rel when built with KEY_REPEAT_RELEASE_EN defined.
module key_repeat #(
  parameter int NUM_KEYS      = 3,
  parameter int HOLD_DELAY    = 6_000_000,
  parameter int REPEAT_PERIOD = 1_500_000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_evt,
  output logic [NUM_KEYS-1:0] key_held
`ifdef KEY_REPEAT_RELEASE_EN
  ,
  output logic [NUM_KEYS-1:0] key_rel
`endif
);

  localparam int MAX_CNT = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_PERIOD - 1);

  localparam logic [NUM_KEYS-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] evt_q;
  logic [NUM_KEYS-1:0] rel_q;
  logic [1:0]          state [NUM_KEYS];
  logic [CW-1:0]       cnt   [NUM_KEYS];

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // NOTE: sequential state uses <= only; blocking here would let later loop
  // iterations or blocks see half-updated values and break sim/synth agreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
      end
      evt_q <= '0;
      rel_q <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        evt_q[k] <= 1'b0;
        rel_q[k] <= 1'b0;
        case (state[k])
          IDLE: begin
            cnt[k] <= '0;
            if (key_s[k]) begin
              state[k] <= HOLD;
              evt_q[k] <= 1'b1;
            end
          end
          HOLD: begin
            // Release takes priority over the terminal count.
            if (!key_s[k]) begin
              state[k] <= IDLE;
              cnt[k]   <= '0;
              rel_q[k] <= 1'b1;
            end else if (cnt[k] == HOLD_LAST) begin
              state[k] <= REPEAT;
              cnt[k]   <= '0;
              evt_q[k] <= 1'b1;
            end else begin
              cnt[k] <= cnt[k] + CW'(1);
            end
          end
          REPEAT: begin
            if (!key_s[k]) begin
              state[k] <= IDLE;
              cnt[k]   <= '0;
              rel_q[k] <= 1'b1;
            end else if (cnt[k] == REPEAT_LAST) begin
              cnt[k]   <= '0;
              evt_q[k] <= 1'b1;
            end else begin
              cnt[k] <= cnt[k] + CW'(1);
            end
          end
          default: begin
            state[k] <= IDLE;
            cnt[k]   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_evt  <= '0;
      key_held <= '0;
    end else begin
      key_evt  <= evt_q;
      key_held <= key_s;
    end
  end

`ifdef KEY_REPEAT_RELEASE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_rel <= '0;
    else        key_rel <= rel_q;
  end
`else
  logic unused_rel;
  assign unused_rel = ^rel_q;
`endif

endmodule
